// File: rtl/pwm_capture_pkg.sv
// Shared defaults and FSM encoding for the PWM capture block.
// DEF_DUTY_W matches the duty resolution used by the board LED PWM driver.
package pwm_capture_pkg;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_DUTY_W = 8;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pwm_div.sv
// Serial restoring unsigned divider: one quotient bit per cycle, MSB first.
// done/quo are valid combinationally in the cycle the last bit is produced.
module pwm_div
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DUTY_W = DEF_DUTY_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CNT_W+DUTY_W-1:0]   num,
    input  logic [CNT_W-1:0]          den,
    output logic                      busy,
    output logic                      done,
    output logic [DUTY_W:0]           quo
);

    localparam int NUM_W  = CNT_W + DUTY_W;
    localparam int Q_W    = DUTY_W + 1;
    localparam int STEP_W = $clog2(Q_W);
    localparam logic [STEP_W-1:0] LAST = STEP_W'(Q_W - 1);

    logic              busy_r;
    logic [STEP_W-1:0] step;
    logic [CNT_W-1:0]  rem;
    logic [Q_W-1:0]    lo;
    logic [Q_W-2:0]    q;
    logic [CNT_W-1:0]  den_r;

    logic [CNT_W:0]    trial;
    logic              ge;
    logic [CNT_W-1:0]  diff;
    logic [CNT_W-1:0]  rem_nxt;
    logic [Q_W-1:0]    q_nxt;
    logic              load;

    // Partial remainder is CNT_W+1 bits wide; after a successful subtract it
    // is below den, so the low CNT_W bits of the difference are exact.
    always_comb begin
        trial   = {rem, lo[Q_W-1]};
        ge      = trial >= {1'b0, den_r};
        diff    = trial[CNT_W-1:0] - den_r;
        rem_nxt = ge ? diff : trial[CNT_W-1:0];
        q_nxt   = {q, ge};
    end

    assign load = start && !busy_r && !abort;
    assign busy = busy_r;
    assign done = busy_r && (step == LAST) && !abort;
    assign quo  = q_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            step   <= '0;
        end else if (abort) begin
            busy_r <= 1'b0;
        end else if (load) begin
            busy_r <= 1'b1;
            step   <= '0;
        end else if (busy_r) begin
            step <= step + 1'b1;
            if (step == LAST)
                busy_r <= 1'b0;
        end
    end

    // Quotient bits beyond the top CNT_W-1 numerator bits are fed in serially.
    always_ff @(posedge clk) begin
        if (load) begin
            rem   <= {1'b0, num[NUM_W-1:Q_W]};
            lo    <= num[Q_W-1:0];
            q     <= '0;
            den_r <= den;
        end else if (busy_r) begin
            rem <= rem_nxt;
            lo  <= {lo[Q_W-2:0], 1'b0};
            q   <= q_nxt[Q_W-2:0];
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and duty of an external PWM input, and flags a
// stalled (constant) input after TIMEOUT cycles without a rising edge.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int          CNT_W   = DEF_CNT_W,
    parameter int          DUTY_W  = DEF_DUTY_W,
    parameter int unsigned TIMEOUT = (1 << CNT_W) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              valid,
    output logic              stuck,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W:0] qv);
        return qv[DUTY_W] ? {DUTY_W{1'b1}} : qv[DUTY_W-1:0];
    endfunction

    logic s1, s, s_d, rise;
    logic [CNT_W-1:0] cnt, hcnt;
    logic [CNT_W-1:0] p_r, h_r;
    cap_state_t state_q, state_d;
    logic capture, do_stall, div_start, drop;
    logic div_busy, div_done;
    logic [DUTY_W:0] div_quo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s1  <= pwm_in;
            s   <= s1;
            s_d <= s;
        end
    end

    assign rise = s && !s_d;

    // The edge cycle itself counts as the first cycle of the new period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (rise) begin
            cnt  <= CNT_W'(1);
            hcnt <= CNT_W'(1);
        end else begin
            cnt  <= sat_inc(cnt, 1'b1);
            hcnt <= sat_inc(hcnt, s);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_WAIT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        do_stall = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (rise)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (rise)
                    capture = 1'b1;
                else if (cnt >= TO_CNT)
                    state_d = ST_STALL;
            end
            ST_STALL: begin
                do_stall = 1'b1;
                state_d  = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    assign div_start = capture && !div_busy;
    assign drop      = capture && div_busy;

    always_ff @(posedge clk) begin
        if (div_start) begin
            p_r <= cnt;
            h_r <= hcnt;
        end
    end

    pwm_div #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .abort (do_stall),
        .num   ({hcnt, {DUTY_W{1'b0}}}),
        .den   (cnt),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (div_quo)
    );

    // A stall report takes priority over a division finishing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= drop;
            valid   <= 1'b0;
            if (do_stall) begin
                duty      <= s ? {DUTY_W{1'b1}} : '0;
                period    <= '0;
                high_time <= s ? TO_CNT : '0;
                valid     <= 1'b1;
                stuck     <= 1'b1;
            end else if (div_done) begin
                duty      <= sat_duty(div_quo);
                period    <= p_r;
                high_time <= h_r;
                valid     <= 1'b1;
                stuck     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_W=16, DUTY_W=8, TIMEOUT=1000).
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [7:0]  duty;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        valid, stuck, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int vld_cnt = 0;
    int ovr_cnt = 0;
    int last_vcyc = 0;
    int prev_vcyc = 0;

    always #5 clk = ~clk;

    pwm_capture #(
        .CNT_W   (16),
        .DUTY_W  (8),
        .TIMEOUT (1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .stuck     (stuck),
        .overrun   (overrun)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (valid === 1'b1) begin
            vld_cnt   <= vld_cnt + 1;
            prev_vcyc <= last_vcyc;
            last_vcyc <= cyc;
        end
        if (overrun === 1'b1)
            ovr_cnt <= ovr_cnt + 1;
    end

    task automatic wave(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < per; i++) begin
                @(posedge clk); #1;
                pwm_in = (i < hi);
            end
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pwm_in = lvl;
        end
    endtask

    task automatic clear_counts();
        @(negedge clk); #1;
        vld_cnt = 0;
        ovr_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pwm_in = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({duty, period, high_time} !== 40'd0) begin n_bad++; $display("FAIL reset_data: got %0d/%0d/%0d want 0/0/0", duty, period, high_time); end
        n_cmp++; if ({valid, stuck, overrun} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {valid, stuck, overrun}); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({duty, period, high_time, valid, stuck, overrun} !== 43'd0) begin n_bad++; $display("FAIL after_reset: outputs not all zero"); end
    endtask

    task automatic test_basic();
        clear_counts();
        wave(100, 25, 3);
        @(negedge clk);
        n_cmp++; if (vld_cnt !== 2) begin n_bad++; $display("FAIL basic_count: got %0d want 2", vld_cnt); end
        n_cmp++; if (period !== 16'd100) begin n_bad++; $display("FAIL basic_period: got %0d want 100", period); end
        n_cmp++; if (high_time !== 16'd25) begin n_bad++; $display("FAIL basic_high: got %0d want 25", high_time); end
        n_cmp++; if (duty !== 8'd64) begin n_bad++; $display("FAIL basic_duty: got %0d want 64", duty); end
        n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL basic_stuck: got %b want 0", stuck); end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        wave(50, 49, 6);
        @(negedge clk);
        n_cmp++; if (vld_cnt !== 6) begin n_bad++; $display("FAIL b2b_count: got %0d want 6", vld_cnt); end
        n_cmp++; if (duty !== 8'd250) begin n_bad++; $display("FAIL b2b_duty: got %0d want 250", duty); end
        n_cmp++; if (period !== 16'd50) begin n_bad++; $display("FAIL b2b_period: got %0d want 50", period); end
        n_cmp++; if (high_time !== 16'd49) begin n_bad++; $display("FAIL b2b_high: got %0d want 49", high_time); end
        n_cmp++; if (last_vcyc - prev_vcyc !== 50) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 50", last_vcyc - prev_vcyc); end
    endtask

    task automatic test_stall_low();
        clear_counts();
        hold(1'b0, 1200);
        @(negedge clk);
        n_cmp++; if (vld_cnt !== 1) begin n_bad++; $display("FAIL low_count: got %0d want 1", vld_cnt); end
        n_cmp++; if ({duty, period, high_time} !== 40'd0) begin n_bad++; $display("FAIL low_data: got %0d/%0d/%0d want 0/0/0", duty, period, high_time); end
        n_cmp++; if (stuck !== 1'b1) begin n_bad++; $display("FAIL low_stuck: got %b want 1", stuck); end
        wave(100, 50, 1);
        @(negedge clk);
        n_cmp++; if (vld_cnt !== 1) begin n_bad++; $display("FAIL rearm_count: got %0d want 1", vld_cnt); end
        n_cmp++; if (stuck !== 1'b1) begin n_bad++; $display("FAIL rearm_stuck: got %b want 1", stuck); end
        wave(100, 50, 1);
        @(negedge clk);
        n_cmp++; if (vld_cnt !== 2) begin n_bad++; $display("FAIL resume_count: got %0d want 2", vld_cnt); end
        n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL resume_stuck: got %b want 0", stuck); end
        n_cmp++; if (duty !== 8'd128) begin n_bad++; $display("FAIL resume_duty: got %0d want 128", duty); end
        n_cmp++; if (period !== 16'd100) begin n_bad++; $display("FAIL resume_period: got %0d want 100", period); end
    endtask

    task automatic test_stall_high();
        clear_counts();
        hold(1'b1, 1200);
        @(negedge clk);
        n_cmp++; if (vld_cnt !== 2) begin n_bad++; $display("FAIL high_count: got %0d want 2", vld_cnt); end
        n_cmp++; if (duty !== 8'd255) begin n_bad++; $display("FAIL high_duty: got %0d want 255", duty); end
        n_cmp++; if (high_time !== 16'd1000) begin n_bad++; $display("FAIL high_high: got %0d want 1000", high_time); end
        n_cmp++; if (period !== 16'd0) begin n_bad++; $display("FAIL high_period: got %0d want 0", period); end
        n_cmp++; if (stuck !== 1'b1) begin n_bad++; $display("FAIL high_stuck: got %b want 1", stuck); end
        hold(1'b1, 500);
        @(negedge clk);
        n_cmp++; if (vld_cnt !== 2) begin n_bad++; $display("FAIL high_quiet: got %0d want 2", vld_cnt); end
    endtask

    task automatic test_overrun();
        clear_counts();
        hold(1'b0, 20);
        wave(8, 3, 20);
        hold(1'b0, 30);
        @(negedge clk);
        n_cmp++; if (ovr_cnt !== 9) begin n_bad++; $display("FAIL ovr_count: got %0d want 9", ovr_cnt); end
        n_cmp++; if (vld_cnt !== 10) begin n_bad++; $display("FAIL ovr_valids: got %0d want 10", vld_cnt); end
        n_cmp++; if (period !== 16'd8) begin n_bad++; $display("FAIL ovr_period: got %0d want 8", period); end
        n_cmp++; if (high_time !== 16'd3) begin n_bad++; $display("FAIL ovr_high: got %0d want 3", high_time); end
        n_cmp++; if (duty !== 8'd96) begin n_bad++; $display("FAIL ovr_duty: got %0d want 96", duty); end
    endtask

    task automatic test_reset_mid_div();
        int v0;
        wave(100, 5, 2);
        v0 = vld_cnt;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            pwm_in = (i < 5);
            if (i == 6) begin
                rst = 1'b1;
                #1;
                n_cmp++; if ({duty, period, high_time, valid, stuck, overrun} !== 43'd0) begin n_bad++; $display("FAIL midrst_zero: duty=%0d period=%0d high=%0d flags=%b want all 0", duty, period, high_time, {valid, stuck, overrun}); end
            end
            if (i == 7) rst = 1'b0;
        end
        wave(100, 5, 1);
        @(negedge clk);
        n_cmp++; if (vld_cnt !== v0) begin n_bad++; $display("FAIL midrst_quiet: got %0d valids want 0", vld_cnt - v0); end
        wave(100, 5, 1);
        @(negedge clk);
        n_cmp++; if (vld_cnt !== v0 + 1) begin n_bad++; $display("FAIL midrst_first: got %0d valids want 1", vld_cnt - v0); end
        n_cmp++; if (period !== 16'd100) begin n_bad++; $display("FAIL midrst_period: got %0d want 100", period); end
        n_cmp++; if (duty !== 8'd12) begin n_bad++; $display("FAIL midrst_duty: got %0d want 12", duty); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall_low();
        test_stall_high();
        test_overrun();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
